// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - F1 start-light sequence checker and driver reaction timer
// Optional best-time tracking is enabled by defining F1_BEST_TIME_EN.
module f1_reaction_timer #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT_MS = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             tick,
    input  logic             btn,
    output logic [CNT_W-1:0] reaction_ms,
    output logic             valid,
    output logic             jump_start,
    output logic             timeout,
    output logic             seq_error,
    output logic [CNT_W-1:0] best_ms
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMING,
        S_ALL_ON,
        S_TIMING,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_MS);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_prev;
    logic             r_btn_q;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CNT_W-1:0] r_reaction, w_reaction_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_jump, w_jump_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_seq_err, w_seq_err_nxt;
    logic             w_press;
    logic             w_legal;

    assign w_press   = btn & ~r_btn_q;
    // A hold is legal because the generator only advances when enabled.
    assign w_legal   = (lights == r_prev) || (lights == {r_prev[6:0], 1'b1});
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev     <= 8'h00;
            r_btn_q    <= 1'b0;
            r_cnt      <= '0;
            r_reaction <= '0;
            r_valid    <= 1'b0;
            r_jump     <= 1'b0;
            r_timeout  <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= lights;
            r_btn_q    <= btn;
            r_cnt      <= w_cnt_nxt;
            r_reaction <= w_reaction_nxt;
            r_valid    <= w_valid_nxt;
            r_jump     <= w_jump_nxt;
            r_timeout  <= w_timeout_nxt;
            r_seq_err  <= w_seq_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_reaction_nxt = r_reaction;
        w_valid_nxt    = r_valid;
        w_jump_nxt     = r_jump;
        w_timeout_nxt  = r_timeout;
        w_seq_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lights == 8'h01) w_state_nxt = S_ARMING;
            end
            S_ARMING: begin
                if (w_press) begin
                    w_jump_nxt     = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_reaction_nxt = '0;
                    w_state_nxt    = S_DONE;
                end else if (!w_legal) begin
                    w_seq_err_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (lights == 8'hFF) begin
                    w_state_nxt    = S_ALL_ON;
                end
            end
            S_ALL_ON: begin
                if (w_press) begin
                    w_jump_nxt     = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_reaction_nxt = '0;
                    w_state_nxt    = S_DONE;
                end else if (lights == 8'h00) begin
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_TIMING;
                end else if (lights != 8'hFF) begin
                    w_seq_err_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_TIMING: begin
                // A press beats a coincident tick, so the count is taken un-incremented.
                if (w_press) begin
                    w_reaction_nxt = r_cnt;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_DONE;
                end else if (lights != 8'h00) begin
                    w_seq_err_nxt  = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (tick) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= TIMEOUT_VAL) begin
                        w_timeout_nxt  = 1'b1;
                        w_valid_nxt    = 1'b1;
                        w_reaction_nxt = TIMEOUT_VAL;
                        w_state_nxt    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (lights == 8'h01) begin
                    w_valid_nxt   = 1'b0;
                    w_jump_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_ARMING;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef F1_BEST_TIME_EN
    logic [CNT_W-1:0] r_best;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= CNT_MAX;
        end else if ((r_state == S_TIMING) && w_press && (r_cnt < r_best)) begin
            r_best <= r_cnt;
        end
    end

    assign best_ms = r_best;
`else
    assign best_ms = CNT_MAX;
`endif

    assign reaction_ms = r_reaction;
    assign valid       = r_valid;
    assign jump_start  = r_jump;
    assign timeout     = r_timeout;
    assign seq_error   = r_seq_err;

endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Consumer side of the F1 start-light sequence.
- Watches the 8-bit thermometer light bus (0x00→0x01→0x03→…→0xFF→0x00) and checks that the sequence is legal.
- Detects the "lights out" event and times the driver's button response in 1 ms ticks.
- Flags jump starts, illegal sequences and timeouts. Sits between the light generator and the display/score logic.

Parameters:
- CNT_W, 16, width of the reaction counter and result outputs.
- TIMEOUT_MS, 1000, tick count after lights-out at which timing aborts with timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- lights  input  8  light pattern from the sequence generator, sampled every clk
- tick  input  1  one-cycle 1 ms strobe
- btn  input  1  driver button, already synchronised to clk, level
- reaction_ms  output  CNT_W  measured reaction time in ticks
- valid  output  1  reaction_ms/flags hold a completed result
- jump_start  output  1  button pressed before lights-out
- timeout  output  1  no press within TIMEOUT_MS ticks
- seq_error  output  1  one-cycle pulse on an illegal light transition
- best_ms  output  CNT_W  best (minimum) valid reaction time, see optional feature

Behaviour:
- Reset: state=IDLE, counter=0, reaction_ms=0, valid=0, jump_start=0, timeout=0, seq_error=0, best_ms=all ones, btn edge register=0. Reset mid-operation aborts the attempt immediately.
- Button event: press = btn rising edge (btn=1 this cycle, 0 last cycle). A held button never creates a second event.
- Legal step: lights equals its previous sampled value (a hold is allowed, since the generator is enable-gated), or equals the next thermometer value ((prev<<1)|1).
- State IDLE:
  - lights==0x01 → ARMING.
  - Any other value is ignored; no error.
- State ARMING:
  - Illegal step → seq_error pulse, → IDLE.
  - lights==0xFF → ALL_ON.
  - Press → jump_start=1, valid=1, reaction_ms=0, → DONE.
- State ALL_ON:
  - lights==0x00 → TIMING, counter=0.
  - lights==0xFF → stay.
  - Any other value → seq_error pulse, → IDLE.
  - Press → jump start, as in ARMING.
- State TIMING:
  - tick increments the counter, saturating at 2^CNT_W−1.
  - Press → reaction_ms=counter, valid=1, → DONE.
  - Press and tick in the same cycle: the press wins and the counter is not incremented.
  - Counter reaches TIMEOUT_MS (on tick) → timeout=1, valid=1, reaction_ms=TIMEOUT_MS, → DONE.
  - lights leaving 0x00 before a press → seq_error pulse, → IDLE.
- State DONE:
  - Hold all result outputs.
  - lights==0x01 (new sequence) → clear valid, jump_start, timeout; → ARMING. Clearing happens in that same cycle.
- Latency: outputs are registered; a press at edge N gives valid=1 at edge N+1.
- Exactly one of {normal, jump_start, timeout} holds while valid=1.
- seq_error pulses for one cycle only and is never asserted while valid=1.

Optional Feature:
- Macro: F1_BEST_TIME_EN.
- Defined: best_ms updates to reaction_ms on every normal (non-jump, non-timeout) result that is smaller than the stored value. It persists across attempts and is cleared to all ones only by rst.
- Undefined: no best-time register; best_ms is tied to all ones.

Test Plan:
- Normal run: lights step 0x00→0x01→…→0xFF (2 cycles each)→0x00, 237 ticks, then btn rises → valid=1, reaction_ms=237, jump_start=0, timeout=0.
- Jump start: btn rises while lights=0x1F → next cycle valid=1, jump_start=1, reaction_ms=0. A following 0x01 clears valid.
- Illegal sequence: 0x01→0x03→0x0F → seq_error high for exactly 1 cycle, state IDLE, valid stays 0.
- Timeout: lights-out, no press for 1000 ticks → timeout=1, valid=1, reaction_ms=1000. Later presses ignored until the next 0x01.
- Tie/hold cases: btn held high from before lights-out → no reaction recorded. Tick and press rising in the same cycle at count 50 → reaction_ms=50.
- Best time (F1_BEST_TIME_EN): runs of 300, 180, 250 → best_ms=180. rst mid-TIMING → all outputs at reset values, best_ms=0xFFFF.
